// File: rtl/two_to_one_mux_if.sv
// two_to_one_mux_if
// Bundles the data, select and status signals of the two-input selector.
// The master side drives A/B/S/en/clr_cnt and observes the outputs.
// The slave side is the selector itself.
interface two_to_one_mux_if #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
);
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 S;
    logic                 en;
    logic                 clr_cnt;
    logic [WIDTH-1:0]     cout;
    logic [WIDTH-1:0]     cout_q;
    logic                 sel_q;
    logic                 sel_changed;
    logic [CNT_WIDTH-1:0] sw_count;

    modport master (
        output A, B, S, en, clr_cnt,
        input  cout, cout_q, sel_q, sel_changed, sw_count
    );

    modport slave (
        input  A, B, S, en, clr_cnt,
        output cout, cout_q, sel_q, sel_changed, sw_count
    );
endinterface

// File: rtl/two_to_one_mux.sv
// two_to_one_mux
// Cell-select primitive for the cellular-automata datapath: S=0 passes A,
// S=1 passes B. The output is available both combinationally (cout) and as a
// registered copy (cout_q, loaded when en=1). sel_q is S delayed by one clock.
// Optional select-activity monitor, enabled by defining TWO_TO_ONE_MUX_SWCNT_EN:
// sel_changed pulses for one cycle after every select transition and sw_count
// saturates at all-ones counting those transitions (clr_cnt clears it).
// Without the macro, sel_changed and sw_count are tied to 0 and clr_cnt is unused.
module two_to_one_mux #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    two_to_one_mux_if.slave   bus
);

    logic [WIDTH-1:0] muxSel;
    logic [WIDTH-1:0] outData_d;
    logic [WIDTH-1:0] outData_q;
    logic             selPrev_q;

    // Selected data word; shared by the combinational output and the register
    always_comb begin
        muxSel = bus.S ? bus.B : bus.A;
    end

    // Registered copy only loads when enabled, otherwise holds its value
    always_comb begin
        outData_d = outData_q;
        if (bus.en) begin
            outData_d = muxSel;
        end
    end

    // Data and select history registers; cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outData_q <= '0;
            selPrev_q <= 1'b0;
        end else begin
            outData_q <= outData_d;
            selPrev_q <= bus.S;
        end
    end

    assign bus.cout   = muxSel;
    assign bus.cout_q = outData_q;
    assign bus.sel_q  = selPrev_q;

`ifdef TWO_TO_ONE_MUX_SWCNT_EN
    logic                 selToggle;
    logic                 selChanged_d;
    logic                 selChanged_q;
    logic [CNT_WIDTH-1:0] swCount_d;
    logic [CNT_WIDTH-1:0] swCount_q;

    // A transition is S differing from the value captured at the previous edge
    always_comb begin
        selToggle    = (bus.S != selPrev_q);
        selChanged_d = selToggle;
    end

    // Saturating counter; a clear wins over a coincident transition
    always_comb begin
        swCount_d = swCount_q;
        if (bus.clr_cnt) begin
            swCount_d = '0;
        end else if (selToggle && (swCount_q != {CNT_WIDTH{1'b1}})) begin
            swCount_d = swCount_q + CNT_WIDTH'(1);
        end
    end

    // Monitor registers; reset drops any pending pulse or count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selChanged_q <= 1'b0;
            swCount_q    <= '0;
        end else begin
            selChanged_q <= selChanged_d;
            swCount_q    <= swCount_d;
        end
    end

    assign bus.sel_changed = selChanged_q;
    assign bus.sw_count    = swCount_q;
`else
    logic unusedClrCnt;

    // Monitor not built: outputs are constant and the clear input is ignored
    always_comb begin
        unusedClrCnt = bus.clr_cnt;
    end

    assign bus.sel_changed = 1'b0;
    assign bus.sw_count    = '0;
`endif

endmodule

// File: tb/tb_two_to_one_mux.sv
// tb_two_to_one_mux
// Directed test of two_to_one_mux with hand-computed expectations.
// Two instances: WIDTH=1/CNT_WIDTH=8 and WIDTH=8/CNT_WIDTH=2.
// Monitor expectations follow TWO_TO_ONE_MUX_SWCNT_EN at compile time.
module tb_two_to_one_mux;

`ifdef TWO_TO_ONE_MUX_SWCNT_EN
    localparam bit SWCNT = 1'b1;
`else
    localparam bit SWCNT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   numChecks;
    int   numFails;

    two_to_one_mux_if #(.WIDTH(1), .CNT_WIDTH(8)) if1 ();
    two_to_one_mux_if #(.WIDTH(8), .CNT_WIDTH(2)) if8 ();

    two_to_one_mux #(.WIDTH(1), .CNT_WIDTH(8)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    two_to_one_mux #(.WIDTH(8), .CNT_WIDTH(2)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic s, input logic e);
        if8.A  = a;
        if8.B  = b;
        if8.S  = s;
        if8.en = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] combExp;
        logic [3:0] idx;
        logic [1:0] satExp [6];
        satExp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        combExp = 8'b1101_1000;
        numChecks = 0;
        numFails  = 0;

        rst_n = 1'b0;
        if1.A = 1'b0; if1.B = 1'b0; if1.S = 1'b0; if1.en = 1'b0; if1.clr_cnt = 1'b0;
        if8.clr_cnt = 1'b0;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        checkOutput("rst_cout_q",      32'(if8.cout_q),      32'h0);
        checkOutput("rst_sel_q",       32'(if8.sel_q),       32'h0);
        checkOutput("rst_sel_changed", 32'(if8.sel_changed), 32'h0);
        checkOutput("rst_sw_count",    32'(if8.sw_count),    32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive {A,B,S} on the 1-bit instance
        for (int i = 0; i < 8; i++) begin
            idx = 4'(i);
            if1.A = idx[2];
            if1.B = idx[1];
            if1.S = idx[0];
            #5;
            checkOutput($sformatf("comb_%0d", i), 32'(if1.cout), 32'(combExp[i]));
        end
        if1.S = 1'b0;

        // Registered data path on the 8-bit instance
        @(negedge clk);
        applyStimulus(8'h3C, 8'hA5, 1'b0, 1'b1);
        tick();
        checkOutput("coutq_a", 32'(if8.cout_q), 32'h3C);
        if8.S = 1'b1;
        tick();
        checkOutput("coutq_b", 32'(if8.cout_q), 32'hA5);
        applyStimulus(8'h3C, 8'hA5, 1'b0, 1'b0);
        #1;
        checkOutput("cout_en0", 32'(if8.cout), 32'h3C);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("coutq_hold_%0d", i), 32'(if8.cout_q), 32'hA5);
            if8.S = ~if8.S;
        end

        // Load known non-zero state, then reset asynchronously between edges
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b1);
        if1.S = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if1.S = ~if1.S;
            tick();
        end
        checkOutput("pre_coutq_ff",  32'(if8.cout_q),   32'hFF);
        checkOutput("pre_swcount_5", 32'(if1.sw_count), SWCNT ? 32'd5 : 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_coutq",       32'(if8.cout_q),      32'h0);
        checkOutput("arst_sel_q",       32'(if8.sel_q),       32'h0);
        checkOutput("arst_sel_changed", 32'(if1.sel_changed), 32'h0);
        checkOutput("arst_sw_count1",   32'(if1.sw_count),    32'h0);
        checkOutput("arst_sel_q1",      32'(if1.sel_q),       32'h0);
        checkOutput("arst_cout_a",      32'(if8.cout),        32'hFF);
        applyStimulus(8'hFF, 8'h5A, 1'b1, 1'b1);
        #1;
        checkOutput("arst_cout_b", 32'(if8.cout), 32'h5A);
        @(negedge clk);
        if8.S = 1'b0;
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_changed", 32'(if8.sel_changed), 32'h0);
        checkOutput("post_rst_count",   32'(if8.sw_count),    32'h0);

        // Toggle S every cycle: counter saturates at 3 on the 2-bit instance
        for (int k = 0; k < 6; k++) begin
            if8.S = (k % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            checkOutput($sformatf("sat_changed_%0d", k), 32'(if8.sel_changed), SWCNT ? 32'd1 : 32'd0);
            checkOutput($sformatf("sat_count_%0d", k),   32'(if8.sw_count),    SWCNT ? 32'(satExp[k]) : 32'd0);
            checkOutput($sformatf("sat_sel_q_%0d", k),   32'(if8.sel_q),       (k % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Clear coincident with a transition: clear wins, pulse still fires
        if8.S = 1'b1;
        if8.clr_cnt = 1'b1;
        tick();
        checkOutput("clr_count",   32'(if8.sw_count),    32'h0);
        checkOutput("clr_changed", 32'(if8.sel_changed), SWCNT ? 32'd1 : 32'd0);
        if8.clr_cnt = 1'b0;
        tick();
        checkOutput("after_clr_changed", 32'(if8.sel_changed), 32'h0);
        checkOutput("after_clr_count",   32'(if8.sw_count),    32'h0);
        checkOutput("after_clr_sel_q",   32'(if8.sel_q),       32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
